// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, captures {pc, instr} from the combinational
// instruction memory into a small prefetch FIFO, and presents the FIFO head to decode.
// Optional build macro MISALIGN_TRAP_EN: trap on misaligned redirect targets instead of
// silently forcing them to word alignment.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_BYTES = 1024,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        fetch_fault,
    output logic        misalign_fault
);

    localparam int          PTR_W   = $clog2(FIFO_DEPTH);
    localparam int          CNT_W   = PTR_W + 1;
    localparam logic [31:0] LAST_PC = 32'(IMEM_BYTES - 4);

    logic [31:0]      pc_q;
    logic [31:0]      fifo_pc    [FIFO_DEPTH];
    logic [31:0]      fifo_instr [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             fetch_fault_q;
    logic             misalign_fault_q;

    logic             pop;
    logic             push;
    logic             pc_in_range;
    logic             not_full;
    logic [31:0]      redirect_target;

    // Handshake: the head transfers on any rising edge where out_valid && out_ready.
    // out_valid never depends on out_ready, and the head is held stable while out_ready is low.
    assign out_valid   = (count != '0);
    assign pop         = out_valid && out_ready;
    assign pc_in_range = (pc_q <= LAST_PC);
    assign not_full    = (count < CNT_W'(FIFO_DEPTH));
    assign push        = !redirect_valid && !fetch_fault_q && !misalign_fault_q
                         && pc_in_range && (not_full || pop);

    assign imem_addr      = pc_q;
    assign out_instr      = out_valid ? fifo_instr[rd_ptr] : 32'h0;
    assign out_pc         = out_valid ? fifo_pc[rd_ptr]    : 32'h0;
    assign fetch_fault    = fetch_fault_q;
    assign misalign_fault = misalign_fault_q;

`ifdef MISALIGN_TRAP_EN
    // A misaligned target leaves the PC where it is; the sticky fault then stops fetch.
    assign redirect_target = (redirect_pc[1:0] != 2'b00) ? pc_q : redirect_pc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            misalign_fault_q <= 1'b0;
        end else if (redirect_valid) begin
            misalign_fault_q <= (redirect_pc[1:0] != 2'b00);
        end
    end
`else
    assign redirect_target  = redirect_pc & 32'hFFFF_FFFC;
    assign misalign_fault_q = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q          <= RESET_PC;
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            count         <= '0;
            fetch_fault_q <= 1'b0;
        end else if (redirect_valid) begin
            pc_q          <= redirect_target;
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            count         <= '0;
            fetch_fault_q <= 1'b0;
        end else begin
            if (push) begin
                pc_q   <= pc_q + 32'd4;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
            if (!pc_in_range) begin
                fetch_fault_q <= 1'b1;
            end
        end
    end

    // Storage needs no reset: out_* are gated by out_valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc[wr_ptr]    <= pc_q;
            fifo_instr[wr_ptr] <= imem_instr;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by randomized
// ready/redirect/reset traffic, compared against a queue-based reference model.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam int          IMEM_BYTES = 1024;
    localparam int          DEPTH      = 2;
    localparam logic [31:0] LAST_PC    = 32'(IMEM_BYTES - 4);

    logic        clk;
    logic        reset;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fetch_fault;
    logic        misalign_fault;

    logic [31:0] mem [0:IMEM_BYTES/4-1];

    // reference model state
    logic [63:0] exp_q[$];
    logic [31:0] m_pc;
    bit          m_ff;
    bit          m_mf;

    int checks;
    int errors;

    fetch_unit #(
        .RESET_PC  (RESET_PC),
        .IMEM_BYTES(IMEM_BYTES),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_addr     (imem_addr),
        .imem_instr    (imem_instr),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_instr     (out_instr),
        .out_pc        (out_pc),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .fetch_fault   (fetch_fault),
        .misalign_fault(misalign_fault)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        if (addr < 32'(IMEM_BYTES)) return mem[addr[9:2]];
        return 32'hDEAD_BEEF;
    endfunction

    assign imem_instr = mem_word(imem_addr);

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        bit has_head;
        has_head = (exp_q.size() != 0);
        check_val({tag, ".imem_addr"}, 64'(imem_addr), 64'(m_pc));
        check_val({tag, ".out_valid"}, 64'(out_valid), 64'(has_head));
        check_val({tag, ".out_pc"}, 64'(out_pc), has_head ? 64'(exp_q[0][63:32]) : 64'h0);
        check_val({tag, ".out_instr"}, 64'(out_instr), has_head ? 64'(exp_q[0][31:0]) : 64'h0);
        check_val({tag, ".fetch_fault"}, 64'(fetch_fault), 64'(m_ff));
        check_val({tag, ".misalign_fault"}, 64'(misalign_fault), 64'(m_mf));
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_pc = RESET_PC;
        m_ff = 1'b0;
        m_mf = 1'b0;
    endtask

    // Next-state of the model for one clock edge, given this cycle's inputs.
    task automatic model_step(input bit ready, input bit rv, input logic [31:0] rpc);
        bit pop;
        bit can_push;
        pop = (exp_q.size() != 0) && ready;
        if (rv) begin
            exp_q.delete();
            m_ff = 1'b0;
`ifdef MISALIGN_TRAP_EN
            if (rpc[1:0] != 2'b00) begin
                m_mf = 1'b1;
            end else begin
                m_mf = 1'b0;
                m_pc = rpc;
            end
`else
            m_pc = {rpc[31:2], 2'b00};
`endif
        end else begin
            can_push = !m_ff && !m_mf && (m_pc <= LAST_PC) && ((exp_q.size() < DEPTH) || pop);
            if (pop) void'(exp_q.pop_front());
            if (can_push) exp_q.push_back({m_pc, mem_word(m_pc)});
            if (m_pc > LAST_PC) m_ff = 1'b1;
            if (can_push) m_pc = m_pc + 32'd4;
        end
    endtask

    // driver: called at a falling edge; drives inputs, advances the model, checks after the edge
    task automatic step(input bit ready, input bit rv, input logic [31:0] rpc);
        out_ready      = ready;
        redirect_valid = rv;
        redirect_pc    = rpc;
        model_step(ready, rv, rpc);
        @(negedge clk);
        check_all("cycle");
    endtask

    task automatic async_reset();
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_all("async_reset");
        @(negedge clk);
        redirect_valid = 1'b0;
        check_all("in_reset");
        reset = 1'b0;
    endtask

    function automatic logic [31:0] random_target();
        case ($urandom_range(0, 3))
            0:       return 32'($urandom_range(0, IMEM_BYTES / 4 - 1)) << 2;
            1:       return 32'h3F0 + (32'($urandom_range(0, 3)) << 2);
            2:       return (32'($urandom_range(0, IMEM_BYTES / 4 - 1)) << 2) | 32'($urandom_range(1, 3));
            default: return 32'h400 + (32'($urandom_range(0, 15)) << 2);
        endcase
    endfunction

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < IMEM_BYTES / 4; i++) begin
            mem[i] = (i < 16) ? 32'(i + 1) * 32'h1111_1111 : $urandom;
        end
        reset          = 1'b1;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all("reset");
        reset = 1'b0;

        // sequential fetch with decode always ready
        step(1'b1, 1'b0, 32'h0);
        check_val("first_pc", 64'(out_pc), 64'h0);
        check_val("first_instr", 64'(out_instr), 64'h1111_1111);
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 32'h0);

        // stall after reset: FIFO fills with 0 and 4, address holds at 8
        async_reset();
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 32'h0);
        check_val("stall_addr", 64'(imem_addr), 64'h8);
        check_val("stall_head", 64'(out_pc), 64'h0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'h0);

        // redirect with a full FIFO
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b1, 32'h40);
        check_val("redirect_bubble", 64'(out_valid), 64'h0);
        step(1'b1, 1'b0, 32'h0);
        check_val("redirect_pc", 64'(out_pc), 64'h40);
        check_val("redirect_instr", 64'(out_instr), 64'(mem[16]));
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0);

        // run off the end of memory, then recover with a redirect
        step(1'b1, 1'b1, 32'h3F8);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'h0);
        check_val("end_fault", 64'(fetch_fault), 64'h1);
        check_val("end_valid", 64'(out_valid), 64'h0);
        step(1'b1, 1'b1, 32'h0);
        check_val("fault_cleared", 64'(fetch_fault), 64'h0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0);

        // misaligned redirect
        step(1'b1, 1'b1, 32'h42);
        step(1'b1, 1'b0, 32'h0);
`ifdef MISALIGN_TRAP_EN
        check_val("misalign_set", 64'(misalign_fault), 64'h1);
        check_val("misalign_halt", 64'(out_valid), 64'h0);
`else
        check_val("misalign_forced", 64'(out_pc), 64'h40);
`endif
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 32'h44);
        step(1'b1, 1'b0, 32'h0);
        check_val("aligned_resume", 64'(out_pc), 64'h44);
        check_val("misalign_clear", 64'(misalign_fault), 64'h0);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 499) == 0) begin
                async_reset();
            end else if ($urandom_range(0, 15) == 0) begin
                step($urandom_range(0, 3) != 0, 1'b1, random_target());
            end else begin
                step($urandom_range(0, 3) != 0, 1'b0, 32'($urandom));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
